d_format_decoder: RTL and testbench
===================================

Name: d_format_decoder

Overview:
- Control unit slice for LEGv8 D-format memory instructions: STUR (store) and LDUR (load).
- Decodes a 32-bit instruction into a 94-bit control word (CW) for the 64-bit datapath: register file, ALU, data memory, PC logic and bus source enables.
- Owns a 1-bit execution-state register so that LDUR runs over two cycles.
- Sits between instruction fetch and the datapath, in parallel with the other format decoders.

Parameters:
- OPC_STUR, 11'b11111000000, STUR opcode.
- OPC_LDUR, 11'b11111000010, LDUR opcode.
- FS_ADD, 5'b01000, ALU function-select code for 64-bit add.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset; clears state.
- i  input  32  current instruction word.
- CW  output  94  control word, combinational from i and state.
- state  output  1  current execution state (0 = first cycle, 1 = LDUR writeback).

Behaviour:
- Instruction fields:
  - opcode = i[31:21]
  - offset = i[20:12]
  - op2 = i[11:10], ignored
  - Rn = i[9:5]
  - Rt = i[4:0]
- CW packing, LSB first:
  - [4:0] DA
  - [9:5] SA
  - [14:10] SB
  - [19:15] FS
  - [21:20] PS
  - [23:22] enable
  - [24] regWrite
  - [25] memWrite
  - [26] PC_sel
  - [27] B_sel
  - [28] status_load
  - [92:29] k
  - [93] next_state
- PS encoding: 00 hold PC, 01 PC+4, 10 PC+k branch, 11 PC from register.
- enable encoding (data bus source): 00 ALU, 01 data memory, 10 PC+4, 11 none (tri-stated).
- k = 9-bit offset extended to 64 bits (extension mode set by the optional feature); byte offset, unscaled.
- Constant in all CW outputs: SA=Rn, SB=Rt, DA=Rt, FS=FS_ADD, B_sel=1, PC_sel=0, status_load=0.
- STUR, state 0:
  - memWrite=1, regWrite=0, enable=11, PS=01, next_state=0.
  - Single cycle; memory address = Rn + k, data = Rt.
- LDUR, state 0:
  - memWrite=0, regWrite=0, enable=11, PS=00, next_state=1.
  - Address phase; PC held.
- LDUR, state 1:
  - memWrite=0, regWrite=1, enable=01, PS=01, next_state=0.
  - Memory data written to Rt.
- Other opcodes (either state):
  - memWrite=0, regWrite=0, enable=11, PS=01, next_state=0.
  - k and register fields still decoded as above.
- STUR decoded while state=1: treated as STUR, state 0 outputs.
- State register:
  - state <= CW[93] on each rising clock edge.
  - reset_n=0 forces state=0 immediately, regardless of clock.
  - CW reflects the state-0 decode of i while reset is held.
- Reset mid-LDUR (state=1): the writeback is abandoned; there is no write after reset release unless LDUR re-runs from state 0.
- No internal latency on CW; it follows i and state combinationally.

Optional Feature:
- Macro D_SIGNED_OFFSET_EN.
- Defined: k = sign-extended offset, {{55{i[20]}}, i[20:12]}; offset 9'h1FF gives k = 64'hFFFF_FFFF_FFFF_FFFF.
- Undefined: k = zero-extended offset, {55'b0, i[20:12]}; offset 9'h1FF gives k = 64'h1FF.

Test Plan:
- Reset: reset_n=0 with i=0 -> state=0; CW[25:24]=00, CW[21:20]=01, CW[93]=0.
- STUR: i=32'b11111000000_000000001_00_10000_00100, state 0 -> SA=16, SB=4, DA=4, FS=01000, B_sel=1, memWrite=1, regWrite=0, enable=11, PS=01, k=1, next_state=0; state stays 0 after a clock.
- LDUR cycle 1: i=32'b11111000010_000000010_00_10001_00100 -> SA=17, DA=4, k=2, memWrite=0, regWrite=0, PS=00, next_state=1.
- LDUR cycle 2: after one clock -> state=1; regWrite=1, enable=01, PS=01, next_state=0; after the next clock state=0.
- Reset mid-LDUR: assert reset_n=0 while state=1 -> state=0 asynchronously, regWrite=0.
- Offset 9'h1FF: with D_SIGNED_OFFSET_EN, k = all ones; without it, k = 64'h1FF. Unknown opcode 32'h0 -> memWrite=0, regWrite=0, PS=01.

Source files
------------

// File: rtl/d_format_decoder.sv
// d_format_decoder: LEGv8 STUR/LDUR control-word decoder with 1-bit execution state.
// Build option D_SIGNED_OFFSET_EN: sign-extend the 9-bit offset into k (zero-extended otherwise).
module d_format_decoder #(
    parameter logic [10:0] OPC_STUR = 11'b11111000000,
    parameter logic [10:0] OPC_LDUR = 11'b11111000010,
    parameter logic [4:0]  FS_ADD   = 5'b01000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] i,
    output logic [93:0] CW,
    output logic        state
);
    logic        state_q, state_d;
    logic [10:0] opcode;
    logic [4:0]  rn, rt;
    logic [63:0] k;
    logic        is_stur, is_ldur, ld_wb, ld_addr;
    logic        mem_write, reg_write, next_state;
    logic [1:0]  ps, enable;

    always_comb begin
        opcode     = i[31:21];
        rn         = i[9:5];
        rt         = i[4:0];
`ifdef D_SIGNED_OFFSET_EN
        k          = {{55{i[20]}}, i[20:12]};
`else
        k          = {55'b0, i[20:12]};
`endif
        is_stur    = opcode == OPC_STUR;
        is_ldur    = opcode == OPC_LDUR;
        ld_wb      = is_ldur && state_q;
        ld_addr    = is_ldur && !state_q;
        mem_write  = is_stur;
        reg_write  = ld_wb;
        enable     = ld_wb ? 2'b01 : 2'b11;
        ps         = ld_addr ? 2'b00 : 2'b01;
        next_state = ld_addr;
        CW         = {next_state, k, 1'b0, 1'b1, 1'b0, mem_write, reg_write,
                      enable, ps, FS_ADD, rt, rn, rt};
        state_d    = next_state;
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state_q <= 1'b0;
        else          state_q <= state_d;

    assign state = state_q;
endmodule

// File: tb/tb_d_format_decoder.sv
// tb_d_format_decoder: randomized and directed checks against a field-level reference model.
module tb_d_format_decoder;
    localparam logic [10:0] STUR = 11'b11111000000;
    localparam logic [10:0] LDUR = 11'b11111000010;

    logic        clock = 0;
    logic        reset_n = 0;
    logic [31:0] i = 0;
    logic [93:0] CW;
    logic        state;
    int          tests = 0;
    int          fails = 0;
    bit          ms = 0;

    d_format_decoder dut (.clock(clock), .reset_n(reset_n), .i(i), .CW(CW), .state(state));

    always #5 clock = ~clock;

    function automatic logic [63:0] model_k(input logic [31:0] ins);
        logic [8:0] off;
        off = ins[20:12];
`ifdef D_SIGNED_OFFSET_EN
        return 64'($signed(off));
`else
        return 64'(off);
`endif
    endfunction

    function automatic bit model_next(input logic [31:0] ins, input bit st);
        return ins[31:21] == LDUR && !st;
    endfunction

    // Builds the expected word by weighted sums of each field rather than bit packing.
    function automatic logic [93:0] model_cw(input logic [31:0] ins, input bit st);
        logic [93:0] w;
        bit          ld, sr, wb;
        int          ps, en;
        sr = ins[31:21] == STUR;
        ld = ins[31:21] == LDUR;
        wb = ld && st;
        ps = (ld && !st) ? 0 : 1;
        en = wb ? 1 : 3;
        w  = 94'(ins[4:0]) + (94'(ins[9:5]) << 5) + (94'(ins[4:0]) << 10) + (94'(8) << 15)
           + (94'(ps) << 20) + (94'(en) << 22) + (94'(wb) << 24) + (94'(sr) << 25)
           + (94'(1) << 27) + (94'(model_k(ins)) << 29) + (94'(model_next(ins, st)) << 93);
        return w;
    endfunction

    task automatic test_reset;
        reset_n = 0;
        i = 0;
        #1;
        tests++;
        if (state !== 1'b0) begin fails++; $display("FAIL reset_state got %0b want 0", state); end
        tests++;
        if (CW[25:24] !== 2'b00 || CW[21:20] !== 2'b01 || CW[93] !== 1'b0) begin
            fails++; $display("FAIL reset_cw got mw/rw=%b ps=%b ns=%b want 00 01 0", CW[25:24], CW[21:20], CW[93]);
        end
        @(negedge clock);
        reset_n = 1;
        ms = 0;
    endtask

    task automatic step_check(input string name, input logic [31:0] ins);
        @(negedge clock);
        i = ins;
        #1;
        tests++;
        if (state !== ms) begin fails++; $display("FAIL %s_state got %0b want %0b", name, state, ms); end
        tests++;
        if (CW !== model_cw(ins, ms)) begin
            fails++; $display("FAIL %s_cw got %h want %h", name, CW, model_cw(ins, ms));
        end
        ms = model_next(ins, ms);
    endtask

    task automatic test_stur;
        logic [31:0] ins;
        ins = 32'b11111000000_000000001_00_10000_00100;
        step_check("stur", ins);
        tests++;
        if (CW[9:5] !== 5'd16 || CW[14:10] !== 5'd4 || CW[4:0] !== 5'd4 || CW[19:15] !== 5'b01000
            || CW[27] !== 1'b1 || CW[25:20] !== 6'b101101 || CW[92:29] !== 64'd1 || CW[93] !== 1'b0) begin
            fails++; $display("FAIL stur_fields got %h", CW);
        end
        step_check("stur_hold", ins);
    endtask

    task automatic test_ldur;
        logic [31:0] ins;
        ins = 32'b11111000010_000000010_00_10001_00100;
        step_check("ldur_c1", ins);
        tests++;
        if (CW[9:5] !== 5'd17 || CW[4:0] !== 5'd4 || CW[92:29] !== 64'd2 || CW[25:24] !== 2'b00
            || CW[21:20] !== 2'b00 || CW[93] !== 1'b1) begin
            fails++; $display("FAIL ldur_c1_fields got %h", CW);
        end
        step_check("ldur_c2", ins);
        tests++;
        if (state !== 1'b1 || CW[24] !== 1'b1 || CW[23:22] !== 2'b01 || CW[21:20] !== 2'b01 || CW[93] !== 1'b0) begin
            fails++; $display("FAIL ldur_c2_fields got st=%0b cw=%h", state, CW);
        end
        step_check("ldur_after", 32'h0);
    endtask

    task automatic test_reset_mid_ldur;
        logic [31:0] ins;
        ins = {LDUR, 21'h0_5A_3};
        step_check("mid_c1", ins);
        step_check("mid_c2", ins);
        reset_n = 0;
        #1;
        tests++;
        if (state !== 1'b0 || CW[24] !== 1'b0) begin
            fails++; $display("FAIL mid_reset got st=%0b rw=%0b want 0 0", state, CW[24]);
        end
        tests++;
        if (CW !== model_cw(ins, 0)) begin fails++; $display("FAIL mid_reset_cw got %h want %h", CW, model_cw(ins, 0)); end
        i = 0;
        #1;
        reset_n = 1;
        ms = 0;
        step_check("mid_after", 32'h0);
    endtask

    task automatic test_offset_boundary;
        step_check("off1ff", {STUR, 9'h1FF, 12'h0AB});
        tests++;
`ifdef D_SIGNED_OFFSET_EN
        if (CW[92:29] !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL off1ff_k got %h want all ones", CW[92:29]); end
`else
        if (CW[92:29] !== 64'h1FF) begin fails++; $display("FAIL off1ff_k got %h want 1ff", CW[92:29]); end
`endif
        step_check("unknown", 32'h0);
        tests++;
        if (CW[25:24] !== 2'b00 || CW[21:20] !== 2'b01) begin
            fails++; $display("FAIL unknown_ctl got mw/rw=%b ps=%b want 00 01", CW[25:24], CW[21:20]);
        end
    endtask

    task automatic test_random;
        logic [31:0] ins;
        for (int n = 0; n < 300; n++) begin
            ins = $urandom;
            case ($urandom_range(0, 2))
                0: ins[31:21] = STUR;
                1: ins[31:21] = LDUR;
                default: ;
            endcase
            step_check("rand", ins);
        end
    endtask

    initial begin
        test_reset;
        test_stur;
        test_ldur;
        test_reset_mid_ldur;
        test_offset_boundary;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
